// File: rtl/count_sequencer_pkg.sv
// Shared types and constants for the count_sequencer controller and its counter.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/sync_counter.sv
// Fully synchronous up/down counter; a load takes priority over a step.
import count_sequencer_pkg::*;

module sync_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Counter register: reset, load, then step; wraps modulo 2^WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      case (dir)
        DIR_UP:   q <= q + ONE;
        DIR_DOWN: q <= q - ONE;
        default:  q <= q;
      endcase
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven sequencer that runs a counter from start to end, one-shot or auto-reload.
import count_sequencer_pkg::*;

module count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic             cmd_dir,
  input  logic             cmd_mode,
  input  logic             step_en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             reload
);

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] start_r, end_r;
  logic             dir_r, mode_r;
  logic             busy_r, done_r, reload_r;
  logic             accept_s, cnt_load_s, cnt_en_s, reload_evt_s;

  assign cmd_ready = (state_r == IDLE);
  assign accept_s  = cmd_valid && cmd_ready;
  assign busy      = busy_r;
  assign done      = done_r;
  assign reload    = reload_r;

  // Next state plus counter controls; abort outranks step_en in LOAD and RUN.
  always_comb begin
    state_next_s = state_r;
    cnt_load_s   = 1'b0;
    cnt_en_s     = 1'b0;
    reload_evt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = LOAD;
        else          state_next_s = IDLE;
      end
      LOAD: begin
        if (abort) begin
          state_next_s = IDLE;
        end else begin
          cnt_load_s   = 1'b1;
          state_next_s = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next_s = IDLE;
        end else if (step_en && (count != end_r)) begin
          cnt_en_s = 1'b1;
        end else if (step_en && (mode_r == MODE_RELOAD)) begin
          cnt_load_s   = 1'b1;
          reload_evt_s = 1'b1;
        end else if (step_en && (mode_r == MODE_ONESHOT)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      reload_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      busy_r   <= (state_next_s == LOAD) || (state_next_s == RUN);
      done_r   <= (state_next_s == DONE);
      reload_r <= reload_evt_s;
    end
  end

  // Command fields are captured only on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_r <= '0;
      end_r   <= '0;
      dir_r   <= 1'b0;
      mode_r  <= 1'b0;
    end else if (accept_s) begin
      start_r <= cmd_start;
      end_r   <= cmd_end;
      dir_r   <= cmd_dir;
      mode_r  <= cmd_mode;
    end else begin
      start_r <= start_r;
      end_r   <= end_r;
      dir_r   <= dir_r;
      mode_r  <= mode_r;
    end
  end

  sync_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (start_r),
    .en       (cnt_en_s),
    .dir      (dir_r),
    .q        (count)
  );

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench: vector table, directed corner sequences, randomized runs vs. a step-position model.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_start = 4'd0;
  logic [3:0] cmd_end = 4'd0;
  logic       cmd_dir = 1'b0;
  logic       cmd_mode = 1'b0;
  logic       step_en = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic       busy, done, reload;

  int pass_cnt = 0;
  int total_cnt = 0;

  count_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_dir(cmd_dir), .cmd_mode(cmd_mode),
    .step_en(step_en), .abort(abort), .count(count), .busy(busy), .done(done), .reload(reload)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, valid;
    logic [3:0] st, en;
    logic       dir, mode, step, abt;
    logic [3:0] e_count;
    logic       e_ready, e_busy, e_done, e_reload;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Present a command, wait (bounded) for the handshake edge, then drop valid.
  task automatic send_cmd(input int s, input int e, input logic d, input logic m);
    cmd_valid = 1'b1;
    cmd_start = s[3:0];
    cmd_end   = e[3:0];
    cmd_dir   = d;
    cmd_mode  = m;
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    chk("cmd_ready_wait", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_ready", cmd_ready, 0);
  endtask

  function automatic int cnt_at(input int s, input logic d, input int pos);
    return d ? ((s - pos) & 15) : ((s + pos) & 15);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, e, d, pos;
    logic dr, md, finished;

    // rst, valid, start, end, dir, mode, step, abort -> count, ready, busy, done, reload
    vecs[0]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    #1;
    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; cmd_valid = vecs[i].valid;
      cmd_start = vecs[i].st; cmd_end = vecs[i].en;
      cmd_dir = vecs[i].dir; cmd_mode = vecs[i].mode;
      step_en = vecs[i].step; abort = vecs[i].abt;
      tick();
      chk($sformatf("vec%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("vec%0d_ready", i), cmd_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("vec%0d_reload", i), reload, vecs[i].e_reload);
    end
    rst = 1'b0; cmd_valid = 1'b0; step_en = 1'b0; abort = 1'b0;

    // Up wrap 14 -> 1: four steps to the terminal event.
    send_cmd(14, 1, 1'b0, 1'b0);
    step_en = 1'b1;
    tick(); chk("wrap_load", count, 14);
    tick(); chk("wrap_15", count, 15);
    tick(); chk("wrap_0", count, 0);
    tick(); chk("wrap_1", count, 1);
    chk("wrap_no_done_yet", done, 0);
    tick(); chk("wrap_done", done, 1); chk("wrap_done_count", count, 1);
    step_en = 1'b0;
    tick(); chk("wrap_idle_ready", cmd_ready, 1); chk("wrap_done_clear", done, 0);

    // Down auto-reload 2 -> 13: reload every 6 steps, never done.
    send_cmd(2, 13, 1'b1, 1'b1);
    step_en = 1'b1;
    tick(); chk("dn_load", count, 2);
    for (int lap = 0; lap < 2; lap++) begin
      for (int k = 1; k <= 5; k++) begin
        tick();
        chk("dn_count", count, (2 - k) & 15);
        chk("dn_reload_low", reload, 0);
        chk("dn_done_low", done, 0);
      end
      tick();
      chk("dn_reload_count", count, 2);
      chk("dn_reload_pulse", reload, 1);
      chk("dn_done_low", done, 0);
    end
    abort = 1'b1;
    tick(); chk("dn_abort_ready", cmd_ready, 1); chk("dn_abort_count", count, 2);
    abort = 1'b0; step_en = 1'b0;

    // Gated steps, then abort together with step at count 7.
    send_cmd(5, 9, 1'b0, 1'b0);
    tick(); chk("gate_load", count, 5);
    step_en = 1'b1; tick(); chk("gate_s1", count, 6);
    step_en = 1'b0; tick(); chk("gate_h1", count, 6);
    step_en = 1'b1; tick(); chk("gate_s2", count, 7);
    step_en = 1'b0; tick(); chk("gate_h2", count, 7);
    step_en = 1'b1; abort = 1'b1;
    tick();
    chk("abort_count", count, 7); chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    step_en = 1'b0; abort = 1'b0;
    tick(); chk("abort_no_late_done", done, 0);

    // start == end, second command held through RUN and DONE.
    send_cmd(4, 4, 1'b0, 1'b0);
    tick(); chk("eq_load", count, 4);
    cmd_valid = 1'b1; cmd_start = 4'd9; cmd_end = 4'd10; cmd_dir = 1'b0; cmd_mode = 1'b0;
    tick(); chk("eq_run_ready", cmd_ready, 0); chk("eq_run_busy", busy, 1);
    tick(); chk("eq_run_count", count, 4);
    step_en = 1'b1;
    tick(); chk("eq_done", done, 1); chk("eq_done_count", count, 4); chk("eq_done_ready", cmd_ready, 0);
    step_en = 1'b0;
    tick(); chk("eq_idle_ready", cmd_ready, 1); chk("eq_idle_busy", busy, 0);
    tick(); chk("eq2_accept_busy", busy, 1); chk("eq2_accept_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    tick(); chk("eq2_load", count, 9);
    step_en = 1'b1;
    tick(); chk("eq2_step", count, 10);
    tick(); chk("eq2_done", done, 1);
    step_en = 1'b0;
    tick(); chk("eq2_idle", cmd_ready, 1);

    // Randomized runs: expected count is start +/- (steps taken modulo run length).
    for (int t = 0; t < 60; t++) begin
      s  = $urandom_range(0, 15);
      e  = $urandom_range(0, 15);
      dr = 1'($urandom_range(0, 1));
      md = 1'($urandom_range(0, 1));
      d  = dr ? ((s - e) & 15) : ((e - s) & 15);
      send_cmd(s, e, dr, md);
      tick(); chk("rnd_load", count, s);
      pos = 0;
      finished = 1'b0;
      for (int c = 0; c < 48 && !finished; c++) begin
        step_en = ($urandom_range(0, 2) != 0);
        abort   = ($urandom_range(0, 39) == 0);
        tick();
        if (abort) begin
          chk("rnd_abort_count", count, cnt_at(s, dr, pos));
          chk("rnd_abort_ready", cmd_ready, 1);
          chk("rnd_abort_done", done, 0);
          chk("rnd_abort_reload", reload, 0);
          finished = 1'b1;
        end else if (step_en && pos < d) begin
          pos++;
          chk("rnd_step_count", count, cnt_at(s, dr, pos));
          chk("rnd_step_reload", reload, 0);
          chk("rnd_step_done", done, 0);
          chk("rnd_step_busy", busy, 1);
        end else if (step_en && md == 1'b0) begin
          chk("rnd_done", done, 1);
          chk("rnd_done_count", count, e);
          step_en = 1'b0;
          tick();
          chk("rnd_post_done_ready", cmd_ready, 1);
          chk("rnd_post_done_low", done, 0);
          finished = 1'b1;
        end else if (step_en) begin
          pos = 0;
          chk("rnd_reload_pulse", reload, 1);
          chk("rnd_reload_count", count, s);
          chk("rnd_reload_done", done, 0);
        end else begin
          chk("rnd_hold_count", count, cnt_at(s, dr, pos));
          chk("rnd_hold_reload", reload, 0);
          chk("rnd_hold_done", done, 0);
        end
        abort = 1'b0;
      end
      step_en = 1'b0;
      if (!finished) begin
        abort = 1'b1;
        tick();
        chk("rnd_cleanup_ready", cmd_ready, 1);
        abort = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
